// File: rtl/seq_div_usign.sv
// Sequential unsigned restoring divider: one trial subtract and one quotient bit per clock.
// Start/done handshake; results are registered and held until the next done.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | iterating, one quotient bit per edge (busy=1)
// DONE  | one-cycle done pulse, may accept a new start
module seq_div_usign #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // After the restore step the partial remainder is always below the divisor,
  // so its top bit is zero and only WIDTH bits need storing.
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH:0]   p_next;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    p_shift = {p_q, dvd_q[WIDTH-1]};
    trial   = p_shift - {1'b0, dvs_q};
    q_bit   = ~trial[WIDTH];
    p_next  = q_bit ? trial : p_shift;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d = RUN;
            p_d     = '0;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        // Quotient bits fill the dividend register from the bottom as it shifts out.
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        p_d   = p_next[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          quotient_d  = {dvd_q[WIDTH-2:0], q_bit};
          remainder_d = p_next[WIDTH-1:0];
          dbz_d       = 1'b0;
          done_d      = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
